nn_input_sequencer: RTL

Upstream feeder for the feed-forward classifier: accepts an 8-bit feature byte stream over a valid/ready handshake, assembles four bytes into one feature vector, and drives the classifier's 9-bit signed inputs x0..x3. Each vector is held stable for the classifier's fixed evaluation latency. At the end of that window the block samples the classifier outputs y0/y1 and emits them as a one-cycle result. A one-vector shadow buffer fills during evaluation, so consecutive vectors run back-to-back.

---
 rtl/nn_input_sequencer.sv | 87 ++++++++
 1 files changed

// File: rtl/nn_input_sequencer.sv
// Byte-stream front end for the feed-forward classifier: packs four feature bytes into
// a vector, holds it on x0..x3 for HOLD_CYCLES, then returns the sampled {y1,y0}.
module nn_input_sequencer #(
  parameter int HOLD_CYCLES = 9,
  parameter bit SIGNED_IN   = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic signed [8:0] x0,
  output logic signed [8:0] x1,
  output logic signed [8:0] x2,
  output logic signed [8:0] x3,
  input  logic              y0,
  input  logic              y1,
  output logic              vec_start,
  output logic              busy,
  output logic              res_valid,
  output logic [1:0]        res_y
);

  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                        state;
  logic [NUM_LANES-1:0][7:0]     shadow;
  logic [NUM_LANES-1:0][8:0]     xv;
  logic [NUM_LANES-1:0][8:0]     xnext;
  logic [2:0]                    fcnt;
  logic [7:0]                    hcnt;
  logic                          full, accept, hold_done, xfer;

  assign full      = (fcnt == 3'd4);
  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign hold_done = (state == HOLD) && (hcnt == 8'd0);
  // A full shadow moves to x0..x3 either from IDLE or on the hold-expiry edge (back-to-back).
  assign xfer      = full && ((state == IDLE) || hold_done);
  assign busy      = (state == HOLD);

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_ext
      assign xnext[i] = {(SIGNED_IN ? shadow[i][7] : 1'b0), shadow[i]};
    end
  endgenerate

  assign x0 = $signed(xv[0]);
  assign x1 = $signed(xv[1]);
  assign x2 = $signed(xv[2]);
  assign x3 = $signed(xv[3]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      shadow    <= '0;
      xv        <= '0;
      fcnt      <= 3'd0;
      hcnt      <= 8'd0;
      vec_start <= 1'b0;
      res_valid <= 1'b0;
      res_y     <= 2'b00;
    end else begin
      vec_start <= xfer;
      res_valid <= hold_done;
      if (hold_done) res_y <= {y1, y0};
      // Fill never coincides with a transfer: in_ready is low whenever the shadow is full.
      if (accept) begin
        shadow[fcnt[1:0]] <= in_data;
        fcnt              <= fcnt + 3'd1;
      end
      if (xfer) begin
        xv    <= xnext;
        fcnt  <= 3'd0;
        hcnt  <= 8'(HOLD_CYCLES - 1);
        state <= HOLD;
      end else if (hold_done) begin
        state <= IDLE;
      end else if (state == HOLD) begin
        hcnt <= hcnt - 8'd1;
      end
    end
  end

endmodule
